// File: rtl/frame_payload_extractor_if.sv
// Payload delivery bundle between the extractor and its consumer.
// Source drives data/type/valid; sink drives ready.
interface frame_payload_extractor_if #(
  parameter int PAYLOAD_BYTES = 10
);
  logic [PAYLOAD_BYTES*8-1:0] pl_data;
  logic                       pl_hdr_type;
  logic                       pl_valid;
  logic                       pl_ready;

  modport master (
    output pl_data,
    output pl_hdr_type,
    output pl_valid,
    input  pl_ready
  );

  modport slave (
    input  pl_data,
    input  pl_hdr_type,
    input  pl_valid,
    output pl_ready
  );
endinterface

// File: rtl/frame_payload_extractor.sv
// Header check and payload assembly behind the frame aligner,
// with a 2-entry output FIFO and frame/drop/error accounting.
module frame_payload_extractor #(
  parameter int          PAYLOAD_BYTES = 10,
  parameter logic [15:0] HDR1          = 16'hAFAA,
  parameter logic [15:0] HDR2          = 16'hBA55,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       fr_data,
  input  logic [3:0]       fr_byte_position,
  input  logic             frame_detect,
  frame_payload_extractor_if.master pl,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       drop_cnt,
  output logic             hdr_err
);

  localparam int          W    = PAYLOAD_BYTES * 8;
  localparam logic [3:0]  LAST = 4'(PAYLOAD_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    COLLECT,
    SKIP
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [7:0]   lsb;
  logic [7:0]   lsb_nx;
  logic [3:0]   prev;
  logic         type_q;
  logic         type_nx;
  logic [W-1:0] asm_q;
  logic [W-1:0] asm_nx;
  logic         push;
  logic         err_nx;
  logic         in_seq;
  logic         start;
  logic [15:0]  hdr_word;

  logic [W:0]   mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         pop;
  logic         full;
  logic         push_ok;
  logic         drop;

  assign in_seq   = frame_detect
                  && (fr_byte_position == prev + 4'd1);
  assign start    = frame_detect
                  && (fr_byte_position == 4'd0);
  assign hdr_word = {fr_data, lsb};

  always_comb begin
    state_nx = state;
    lsb_nx   = lsb;
    type_nx  = type_q;
    asm_nx   = asm_q;
    push     = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE, SKIP: begin
        if (start) begin
          lsb_nx   = fr_data;
          state_nx = HDR;
        end else if (fr_byte_position == 4'd0) begin
          state_nx = IDLE;
        end
      end
      HDR, COLLECT: begin
        // Broken lock or sequence drops the partial frame silently
        if (!in_seq) begin
          state_nx = start ? HDR : IDLE;
          if (start) lsb_nx = fr_data;
        end else if (state == HDR) begin
          unique case (1'b1)
            (hdr_word == HDR1): begin
              type_nx  = 1'b0;
              state_nx = COLLECT;
            end
            (hdr_word == HDR2): begin
              type_nx  = 1'b1;
              state_nx = COLLECT;
            end
            default: begin
              err_nx   = 1'b1;
              state_nx = SKIP;
            end
          endcase
        end else begin
          for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (fr_byte_position == 4'(i + 2))
              asm_nx[i*8 +: 8] = fr_data;
          end
          if (fr_byte_position == LAST) begin
            push     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lsb     <= '0;
      prev    <= '0;
      type_q  <= 1'b0;
      asm_q   <= '0;
      hdr_err <= 1'b0;
    end else begin
      state   <= state_nx;
      lsb     <= lsb_nx;
      prev    <= fr_byte_position;
      type_q  <= type_nx;
      asm_q   <= asm_nx;
      hdr_err <= err_nx;
    end
  end

  assign pl.pl_valid    = (count != 2'd0);
  assign pl.pl_data     = pl.pl_valid ? mem[rd_ptr][W-1:0] : '0;
  assign pl.pl_hdr_type = pl.pl_valid ? mem[rd_ptr][W] : 1'b0;

  assign pop     = pl.pl_valid && pl.pl_ready;
  assign full    = (count == 2'd2);
  // A simultaneous pop frees the slot the push lands in
  assign push_ok = push && (!full || pop);
  assign drop    = push && !push_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {type_q, asm_nx};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push_ok)
        frame_cnt <= frame_cnt + CNT_W'(1);
      if (drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
